// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Handles divide-by-zero and signed overflow in one cycle; other operations take 32 iterations.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            rem_op_q, rem_op_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] result_q, result_d;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  // Operand decode for a newly accepted request.
  logic            is_signed_s, s1_neg_s, s2_neg_s, div_zero_s, overflow_s;
  logic [XLEN-1:0] abs1_s, abs2_s, special_s;

  always_comb begin
    is_signed_s = ~op_i[0];
    s1_neg_s    = is_signed_s & rs1_i[XLEN-1];
    s2_neg_s    = is_signed_s & rs2_i[XLEN-1];
    abs1_s      = s1_neg_s ? negate(rs1_i) : rs1_i;
    abs2_s      = s2_neg_s ? negate(rs2_i) : rs2_i;
    div_zero_s  = (rs2_i == {XLEN{1'b0}});
    overflow_s  = is_signed_s & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == {XLEN{1'b1}});
    if (div_zero_s) begin
      special_s = op_i[1] ? rs1_i : {XLEN{1'b1}};
    end else begin
      special_s = op_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One restoring iteration plus the sign-corrected result used on the last one.
  logic [XLEN:0]   shift_s, trial_s, rem_nx_s;
  logic [XLEN-1:0] quo_nx_s, q_fix_s, r_fix_s, final_s;
  logic            ge_s;

  always_comb begin
    shift_s  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    trial_s  = shift_s - {1'b0, divisor_q};
    ge_s     = ~trial_s[XLEN];
    rem_nx_s = ge_s ? trial_s : shift_s;
    quo_nx_s = {quo_q[XLEN-2:0], ge_s};
    q_fix_s  = quo_neg_q ? negate(quo_nx_s) : quo_nx_s;
    r_fix_s  = rem_neg_q ? negate(rem_nx_s[XLEN-1:0]) : rem_nx_s[XLEN-1:0];
    final_s  = rem_op_q ? r_fix_s : q_fix_s;
  end

  // Next-state logic; flush always wins and never touches result.
  always_comb begin
    state_d   = state_q;
    rem_op_d  = rem_op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    count_d   = count_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          rem_op_d  = op_i[1];
          quo_neg_d = s1_neg_s ^ s2_neg_s;
          rem_neg_d = s1_neg_s;
          divisor_d = abs2_s;
          quo_d     = abs1_s;
          rem_d     = {(XLEN+1){1'b0}};
          count_d   = {CW{1'b0}};
          if (div_zero_s || overflow_s) begin
            result_d = special_s;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d   = rem_nx_s;
          quo_d   = quo_nx_s;
          count_d = count_q + CW'(1);
          if (count_q == CW'(XLEN-1)) begin
            result_d = final_s;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rem_op_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      divisor_q <= {XLEN{1'b0}};
      rem_q     <= {(XLEN+1){1'b0}};
      quo_q     <= {XLEN{1'b0}};
      count_q   <= {CW{1'b0}};
      result_q  <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      rem_op_q  <= rem_op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      count_q   <= count_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = (state_q == ST_CALC);
  assign valid_o  = (state_q == ST_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed test-plan cases plus random operations
// compared against an arithmetic reference model.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .flush_i(flush), .busy_o(busy), .valid_o(valid), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics written directly from the ISA rules.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Present a request for one edge; returns at the negedge after acceptance.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Edges after acceptance until valid, bounded; also counts busy cycles.
  task automatic wait_valid(output int edges, output int busy_cnt);
    edges = 0; busy_cnt = 0;
    while (valid !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int e, bc, lat;
    logic [31:0] exp;
    exp = model(o, a, b);
    lat = is_special(o, a, b) ? 0 : 32;
    launch(o, a, b);
    wait_valid(e, bc);
    check({tag, "/result"}, result, exp);
    check({tag, "/latency"}, 32'(e), 32'(lat));
    check({tag, "/busy_cycles"}, 32'(bc), 32'(lat));
    @(negedge clk);
    check({tag, "/valid_pulse"}, {31'd0, valid}, 32'd0);
    check({tag, "/held"}, result, exp);
  endtask

  initial begin
    int e, bc;
    logic [31:0] prev;
    bit seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset/busy", {31'd0, busy}, 32'd0);
    check("reset/valid", {31'd0, valid}, 32'd0);
    check("reset/result", result, 32'd0);
    rst = 1'b0;

    run("div_100_7",   2'b00, 32'd100, 32'd7);
    run("rem_100_7",   2'b10, 32'd100, 32'd7);
    run("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2);
    run("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2);
    run("divu_max_1",  2'b01, 32'hFFFF_FFFF, 32'd1);
    run("remu_max_16", 2'b11, 32'hFFFF_FFFF, 32'h10);
    run("div_by_0",    2'b00, 32'h1234, 32'd0);
    run("rem_by_0",    2'b10, 32'h1234, 32'd0);
    run("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run("divu_big",    2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div_min_m2",  2'b00, 32'h8000_0000, 32'hFFFF_FFFE);

    // Back-to-back: second request presented during the DONE cycle.
    launch(2'b01, 32'd50, 32'd5);
    wait_valid(e, bc);
    check("b2b/first_result", result, 32'd10);
    check("b2b/first_latency", 32'(e), 32'd32);
    start = 1'b1; op = 2'b11; rs1 = 32'd50; rs2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("b2b/busy_after", {31'd0, busy}, 32'd1);
    wait_valid(e, bc);
    check("b2b/second_result", result, 32'd1);
    check("b2b/second_latency", 32'(e), 32'd32);
    check("b2b/second_busy", 32'(bc), 32'd32);

    // Flush at iteration 10.
    prev = result;
    launch(2'b00, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush/busy", {31'd0, busy}, 32'd0);
    check("flush/valid", {31'd0, valid}, 32'd0);
    seen = 1'b0;
    repeat (36) begin
      if (valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("flush/no_pulse", {31'd0, seen}, 32'd0);
    check("flush/result_kept", result, prev);
    run("div_9_3", 2'b00, 32'd9, 32'd3);

    // Flush in DONE clears valid the next cycle.
    launch(2'b00, 32'd5, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done/valid", {31'd0, valid}, 32'd0);
    check("flush_done/result", result, 32'hFFFF_FFFF);

    // start_i during CALC is ignored.
    launch(2'b01, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b10; rs1 = 32'd5; rs2 = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_valid(e, bc);
    check("calc_start/result", result, 32'd142);
    check("calc_start/latency", 32'(6 + e), 32'd32);

    // Asynchronous reset mid-operation.
    launch(2'b00, 32'd77, 32'd5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst/busy", {31'd0, busy}, 32'd0);
    check("arst/valid", {31'd0, valid}, 32'd0);
    check("arst/result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst/idle_busy", {31'd0, busy}, 32'd0);
    check("arst/idle_valid", {31'd0, valid}, 32'd0);
    run("after_rst", 2'b10, 32'hFFFF_FF9C, 32'd7);

    // Random operations across operand classes.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      int kind;
      o    = 2'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 5));
      a    = $urandom;
      b    = $urandom;
      case (kind)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
        3: b = {28'($signed(-1)), 4'($urandom)};
        default: ;
      endcase
      run($sformatf("rand%0d", i), o, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M divide/remainder operations (OP_DIV, OP_DIVU, OP_REM, OP_REMU).
- Sits in the execute stage, directly downstream of the control unit's alu_ctrl decode.
- Execute stalls the pipeline on busy_o and takes result_o when valid_o is high.
- Handles the RISC-V divide-by-zero and signed-overflow results without iterating.

Parameters:
- XLEN, 32, operand and result width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  request a new operation; sampled in IDLE or DONE only.
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_i  input  XLEN  dividend.
- rs2_i  input  XLEN  divisor.
- flush_i  input  1  abort the current operation (pipeline flush or trap).
- busy_o  output  1  high in CALC.
- valid_o  output  1  result_o valid; high in DONE for exactly one cycle.
- result_o  output  XLEN  quotient or remainder; held until the next result is written.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy_o=0, valid_o=0, result_o=0, all internal registers 0. Reset in the middle of an operation discards it.

States:
- IDLE: start_i=1 and flush_i=0 at edge T0 → latch op, operand signs and operands.
  - Divisor==0 → DONE. DIV/DIVU result=0xFFFFFFFF; REM/REMU result=rs1_i.
  - Signed overflow (DIV/REM, rs1_i=0x80000000, rs2_i=0xFFFFFFFF) → DONE. DIV result=0x80000000; REM result=0.
  - Otherwise → CALC, count=0.
- CALC: each edge performs one iteration.
  - Shift {rem,quo} left by 1; trial-subtract the divisor from the 33-bit partial remainder; if non-negative, keep the difference and set quotient bit 0.
  - count increments each edge. After the 32nd iteration (edge T32), apply sign correction, write result_o and go to DONE.
- DONE: valid_o=1 for one cycle.
  - Next edge: start_i=1 → same acceptance as IDLE (back-to-back operation allowed).
  - Otherwise → IDLE.
- flush_i=1 at any edge → IDLE. A flush at the completion edge suppresses that result; a flush in DONE clears valid_o on the next cycle. result_o is not updated by a flush. flush_i wins over a simultaneous start_i.
- start_i during CALC is ignored; operands are not re-latched.

Latency:
- Special cases: valid_o high in the cycle after T0 (1 cycle).
- Normal operations: valid_o high in the cycle after T32 (32 cycles).

Arithmetic:
- Signed ops divide absolute values (two's-complement negate; 0x80000000 treated as unsigned magnitude).
- Quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
- Unsigned ops use the operands unchanged.
- Partial remainder register is XLEN+1 bits; no other widening.
- Invariant: dividend = quotient×divisor + remainder, with |remainder| < |divisor|.

Test Plan:
- DIV 100/7 → result 14 (0x0000000E) after 32 cycles; REM 100/7 → 2.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; REMU 0xFFFFFFFF/0x10 → 0xF.
- Divide by zero: DIV 0x1234/0 → 0xFFFFFFFF and REM 0x1234/0 → 0x1234, each with valid_o one cycle after start. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Back-to-back: start DIVU 50/5 and hold start_i with REMU 50/7 in the DONE cycle → valid pulses with 10, then 1 exactly 32 cycles later; busy_o stays high during CALC.
- Flush at iteration 10 → busy_o low next cycle, no valid_o pulse, result_o unchanged. A following DIV 9/3 → 3.
- start_i pulsed during CALC → no effect on result. rst_i asserted mid-CALC → all outputs 0 immediately (asynchronous), IDLE after release.
